// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the EX-stage radix-2 restoring divider.
// Imported by the divider and its bus interface.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  localparam logic [DIV_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
// Signal names keep the divider's _i/_o port-direction suffixes.
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// Operates on magnitudes and fixes signs on the final step.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               signed_q, signed_d;
  logic               dvd_sign_q, dvd_sign_d;
  logic               dsr_sign_q, dsr_sign_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               req;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  assign req = bus.start_i & ~bus.annul_i;

  // A negative trial difference means the divisor did not fit: keep the shifted remainder.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dsr_q};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], q_bit};
  assign rem_fix  = (signed_q && dvd_sign_q) ? negate(rem_next) : rem_next;
  assign quo_fix  = (signed_q && (dvd_sign_q ^ dsr_sign_q)) ? negate(quo_next) : quo_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    signed_d   = signed_q;
    dvd_sign_d = dvd_sign_q;
    dsr_sign_d = dsr_sign_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_NOT_READY;
        if (req) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            dvd_d      = abs_val(bus.opdata1_i, bus.signed_div_i);
            dsr_d      = abs_val(bus.opdata2_i, bus.signed_div_i);
            rem_d      = '0;
            quo_d      = '0;
            cnt_d      = '0;
            signed_d   = bus.signed_div_i;
            dvd_sign_d = bus.opdata1_i[WIDTH-1];
            dsr_sign_d = bus.opdata2_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = DIV_NOT_READY;
        state_d  = req ? DIV_END : DIV_FREE;
      end
      DIV_ON: begin
        if (!req) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_NOT_READY;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (req) begin
          ready_d = DIV_READY;
        end else begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_NOT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      signed_q   <= 1'b0;
      dvd_sign_q <= 1'b0;
      dsr_sign_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      signed_q   <= signed_d;
      dvd_sign_q <= dvd_sign_d;
      dsr_sign_q <= dsr_sign_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = req & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// annul, reset abort and result hold, all against hand-computed values.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic exp_ready, input logic exp_busy);
    checkVal({tag, ".ready"}, {63'b0, bus.ready_o}, {63'b0, exp_ready});
    checkVal({tag, ".busy"}, {63'b0, bus.busy_o}, {63'b0, exp_busy});
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] exp_result,
                             input logic exp_ready, input logic exp_busy);
    checkVal({tag, ".result"}, bus.result_o, exp_result);
    checkFlags(tag, exp_ready, exp_busy);
  endtask

  task automatic applyStimulus(input logic start, input logic annul, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
    bus.start_i      = start;
    bus.annul_i      = annul;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
  endtask

  // Full transaction: ready after edge 33, operands scrambled mid-op, hold, then release.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q, input logic [31:0] exp_r);
    applyStimulus(DIV_START, 1'b0, sgn, a, b);
    #1;
    checkFlags({tag, ".pre"}, 1'b0, 1'b1);
    for (int e = 0; e <= 32; e++) begin
      tick();
      if (e == 10) begin
        bus.opdata1_i = 32'h5A5A_5A5A;
        bus.opdata2_i = 32'h0000_0001;
      end
      checkFlags({tag, ".run"}, 1'b0, 1'b1);
    end
    tick();
    checkOutput({tag, ".done"}, {exp_r, exp_q}, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput({tag, ".hold"}, {exp_r, exp_q}, 1'b1, 1'b0);
    applyStimulus(DIV_STOP, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput({tag, ".drop"}, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(DIV_STOP, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("reset", 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("idle", 64'h0, 1'b0, 1'b0);

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0);

    applyStimulus(DIV_START, 1'b0, 1'b0, 32'd55, 32'd0);
    #1;
    checkFlags("byzero.pre", 1'b0, 1'b1);
    tick();
    checkFlags("byzero.e0", 1'b0, 1'b1);
    bus.opdata1_i = 32'd1234;
    bus.opdata2_i = 32'd5;
    tick();
    checkFlags("byzero.e1", 1'b0, 1'b1);
    tick();
    checkOutput("byzero.e2", 64'h0, 1'b1, 1'b0);
    tick();
    checkOutput("byzero.hold", 64'h0, 1'b1, 1'b0);
    applyStimulus(DIV_STOP, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("byzero.drop", 64'h0, 1'b0, 1'b0);

    applyStimulus(DIV_START, 1'b0, 1'b0, 32'd1000, 32'd3);
    for (int e = 0; e <= 10; e++) tick();
    checkFlags("annul.pre", 1'b0, 1'b1);
    bus.annul_i = 1'b1;
    #1;
    checkFlags("annul.busy", 1'b0, 1'b0);
    tick();
    checkOutput("annul.free", 64'h0, 1'b0, 1'b0);
    runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    applyStimulus(DIV_START, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    for (int e = 0; e <= 5; e++) tick();
    rst = 1'b1;
    bus.start_i = DIV_STOP;
    tick();
    checkOutput("rst_abort", 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rst_idle", 64'h0, 1'b0, 1'b0);
    runDiv("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
